// File: rtl/nco_pkg.sv
// Shared NCO definitions: word width, run-mode encodings, FSM states and the
// phase-quadrant constants that the downstream rotator also relies on.
package nco_pkg;

  localparam int unsigned NCO_PW = 32;

  typedef enum logic [1:0] {
    MODE_TONE     = 2'b00,
    MODE_SINGLE   = 2'b01,
    MODE_REPEAT   = 2'b10,
    MODE_TONE_ALT = 2'b11
  } nco_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } nco_state_e;

  // Full circle is 2^NCO_PW, so the top two phase bits select the quadrant.
  localparam logic [NCO_PW-1:0] PHASE_QUARTER = 32'h4000_0000;
  localparam logic [NCO_PW-1:0] PHASE_HALF    = 32'h8000_0000;

  function automatic logic [1:0] phase_quadrant(input logic [NCO_PW-1:0] phase);
    return phase[NCO_PW-1 -: 2];
  endfunction

endpackage

// File: rtl/nco_freq_stepper.sv
// Frequency register for sweeps: steps by +/-delta, detects the terminal point
// and either clamps to the stop word or reloads the start word.
module nco_freq_stepper #(
  parameter int unsigned PW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          reload_i,
  input  logic [PW-1:0] start_fw_i,
  input  logic [PW-1:0] stop_fw_i,
  input  logic [DW-1:0] delta_i,
  output logic [PW-1:0] freq_o,
  output logic          terminal_o
);

  logic [PW-1:0] freq_q, freq_d;
  logic          dir_up_q, dir_up_d;
  logic [PW:0]   delta_ext, nxt;
  logic          at_end;

  assign delta_ext = {{(PW + 1 - DW){1'b0}}, delta_i};
  assign nxt       = dir_up_q ? ({1'b0, freq_q} + delta_ext) : ({1'b0, freq_q} - delta_ext);
  // A borrow on the down path sets nxt[PW]; that is below any stop word.
  assign at_end    = dir_up_q ? (nxt >= {1'b0, stop_fw_i})
                              : (nxt[PW] || (nxt <= {1'b0, stop_fw_i}));

  always_comb begin
    freq_d   = freq_q;
    dir_up_d = dir_up_q;
    if (load_i) begin
      freq_d   = start_fw_i;
      dir_up_d = (stop_fw_i >= start_fw_i);
    end else if (step_i) begin
      if (at_end) begin
        freq_d = reload_i ? start_fw_i : stop_fw_i;
      end else begin
        freq_d = nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freq_q   <= '0;
      dir_up_q <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign freq_o     = freq_q;
  assign terminal_o = step_i & at_end;

endmodule

// File: rtl/nco_sweep_phase_gen.sv
// Phase generator feeding the CORDIC rotator: phase accumulator plus offset,
// with tone / single-chirp / repeating-chirp frequency control.
module nco_sweep_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned PW = NCO_PW,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_start_fw,
  input  logic [PW-1:0] cfg_stop_fw,
  input  logic [DW-1:0] cfg_delta,
  input  logic [PW-1:0] cfg_phase_ofs,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
  output logic [PW-1:0] phase_out,
  output logic          phase_valid,
  output logic          busy,
  output logic          sweep_done
);

  nco_state_e    state_q;
  nco_mode_e     mode_q;
  logic [PW-1:0] acc_q, phase_q, start_fw_q, stop_fw_q, ofs_q;
  logic [DW-1:0] delta_q;
  logic          cfg_loaded_q, phase_valid_q, sweep_done_q;

  logic [PW-1:0] freq;
  logic          terminal, cfg_xfer, start_ok, ce_ok, sweep_mode, step;

  assign cfg_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign cfg_xfer   = cfg_valid & cfg_ready;
  // start sees the registered config, so a same-cycle transfer does not affect it.
  assign start_ok   = (state_q == StIdle) & start & cfg_loaded_q & ~abort;
  assign ce_ok      = ce & busy & ~abort;
  assign sweep_mode = (mode_q == MODE_SINGLE) || (mode_q == MODE_REPEAT);
  assign step       = ce_ok & (state_q == StRun) & sweep_mode;

  nco_freq_stepper #(
    .PW (PW),
    .DW (DW)
  ) u_stepper (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (start_ok),
    .step_i     (step),
    .reload_i   (mode_q == MODE_REPEAT),
    .start_fw_i (start_fw_q),
    .stop_fw_i  (stop_fw_q),
    .delta_i    (delta_q),
    .freq_o     (freq),
    .terminal_o (terminal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      mode_q        <= MODE_TONE;
      acc_q         <= '0;
      phase_q       <= '0;
      start_fw_q    <= '0;
      stop_fw_q     <= '0;
      ofs_q         <= '0;
      delta_q       <= '0;
      cfg_loaded_q  <= 1'b0;
      phase_valid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      phase_valid_q <= ce_ok;
      sweep_done_q  <= terminal;
      if (cfg_xfer) begin
        start_fw_q   <= cfg_start_fw;
        stop_fw_q    <= cfg_stop_fw;
        delta_q      <= cfg_delta;
        ofs_q        <= cfg_phase_ofs;
        mode_q       <= nco_mode_e'(cfg_mode);
        cfg_loaded_q <= 1'b1;
      end
      if (ce_ok) begin
        phase_q <= acc_q + ofs_q;
        acc_q   <= acc_q + freq;
      end
      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q <= StRun;
              acc_q   <= '0;
            end
          end
          StRun: begin
            if (terminal && (mode_q == MODE_SINGLE)) begin
              state_q <= StHold;
            end
          end
          StHold:  state_q <= StHold;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign phase_out   = phase_q;
  assign phase_valid = phase_valid_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_nco_sweep_phase_gen.sv
// Directed bench for nco_sweep_phase_gen: expected phases queued as ce is driven,
// compared when phase_valid appears.
module tb_nco_sweep_phase_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start_fw = '0;
  logic [31:0] cfg_stop_fw = '0;
  logic [31:0] cfg_delta = '0;
  logic [31:0] cfg_phase_ofs = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] phase_out;
  logic        phase_valid;
  logic        busy;
  logic        sweep_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = '0;

  nco_sweep_phase_gen #(
    .PW (32),
    .DW (32)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ce            (ce),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_start_fw  (cfg_start_fw),
    .cfg_stop_fw   (cfg_stop_fw),
    .cfg_delta     (cfg_delta),
    .cfg_phase_ofs (cfg_phase_ofs),
    .cfg_mode      (cfg_mode),
    .start         (start),
    .abort         (abort),
    .phase_out     (phase_out),
    .phase_valid   (phase_valid),
    .busy          (busy),
    .sweep_done    (sweep_done)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; ev says a phase is expected from this ce, ep is its value.
  task automatic tick(input logic c, input logic ev, input logic [31:0] ep, input logic ed);
    ce = c;
    if (ev) sb_q.push_back(ep);
    @(posedge clock);
    #1;
    ce = 1'b0;
    chk("phase_valid", {31'b0, phase_valid}, {31'b0, ev});
    chk("sweep_done", {31'b0, sweep_done}, {31'b0, ed});
    if (phase_valid) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      else begin
        last_exp = sb_q.pop_front();
        chk("phase_out", phase_out, last_exp);
      end
    end else begin
      chk("phase_hold", phase_out, last_exp);
    end
  endtask

  task automatic load_cfg(input logic [31:0] sfw, input logic [31:0] pfw, input logic [31:0] dl,
                          input logic [31:0] ofs, input logic [1:0] md);
    chk("cfg_ready_idle", {31'b0, cfg_ready}, 32'd1);
    cfg_start_fw = sfw; cfg_stop_fw = pfw; cfg_delta = dl; cfg_phase_ofs = ofs; cfg_mode = md;
    cfg_valid = 1'b1;
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(input logic exp_busy);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, {31'b0, exp_busy});
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, phase_valid}, 32'd0);
    chk("abort_done", {31'b0, sweep_done}, 32'd0);
    chk("abort_hold", phase_out, last_exp);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_phase", phase_out, 32'd0);
    chk("rst_valid", {31'b0, phase_valid}, 32'd0);
    chk("rst_done", {31'b0, sweep_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // start before any config is ignored
    do_start(1'b0);

    // Fixed tone with natural wrap
    load_cfg(32'h1000_0000, 32'h0, 32'h0, 32'h0, 2'b00);
    abort = 1'b1;
    do_start(1'b0);
    abort = 1'b0;
    do_start(1'b1);
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b1, 32'(i) * 32'h1000_0000, 1'b0);
    do_abort();

    // Single up-sweep 100 -> 130 step 10, then hold at 130
    load_cfg(32'd100, 32'd130, 32'd10, 32'd0, 2'b01);
    do_start(1'b1);
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 32'd100, 1'b0);
    tick(1'b1, 1'b1, 32'd210, 1'b1);
    tick(1'b1, 1'b1, 32'd330, 1'b0);
    tick(1'b1, 1'b1, 32'd460, 1'b0);
    tick(1'b1, 1'b1, 32'd590, 1'b0);
    chk("hold_busy", {31'b0, busy}, 32'd1);
    do_abort();

    // Repeating down-sweep 200 -> 170 step 20
    load_cfg(32'd200, 32'd170, 32'd20, 32'd0, 2'b10);
    do_start(1'b1);
    tick(1'b1, 1'b1, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 32'd200, 1'b1);
    tick(1'b1, 1'b1, 32'd380, 1'b0);
    tick(1'b1, 1'b1, 32'd580, 1'b1);
    tick(1'b1, 1'b1, 32'd760, 1'b0);
    tick(1'b1, 1'b1, 32'd960, 1'b1);
    do_abort();

    // ce gated 1-in-4 with a quarter-turn offset
    load_cfg(32'h0100_0000, 32'h0, 32'h0, 32'h4000_0000, 2'b00);
    do_start(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 32'h4000_0000 + 32'(k) * 32'h0100_0000, 1'b0);
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    end
    do_abort();

    // Config is refused while running; abort mid-sweep and restart
    load_cfg(32'd1000, 32'd5000, 32'd100, 32'd7, 2'b01);
    do_start(1'b1);
    tick(1'b1, 1'b1, 32'd7, 1'b0);
    cfg_start_fw = 32'd9; cfg_phase_ofs = 32'd99; cfg_mode = 2'b00;
    cfg_valid = 1'b1;
    #1;
    chk("cfg_ready_run", {31'b0, cfg_ready}, 32'd0);
    tick(1'b1, 1'b1, 32'd1007, 1'b0);
    cfg_valid = 1'b0;
    tick(1'b1, 1'b1, 32'd2107, 1'b0);
    do_abort();
    do_start(1'b1);
    tick(1'b1, 1'b1, 32'd7, 1'b0);
    tick(1'b1, 1'b1, 32'd1007, 1'b0);
    tick(1'b1, 1'b1, 32'd2107, 1'b0);

    // Asynchronous reset mid-run
    ce = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_phase", phase_out, 32'd0);
    chk("arst_valid", {31'b0, phase_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    ce = 1'b0;
    sb_q.delete();
    last_exp = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("arst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    do_start(1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
